// File: rtl/goodness_label_select.sv
// Forward-Forward inference back-end: sums per-layer goodness per candidate label and reports the arg-max label.
// Optional GLS_SCORE_TABLE_EN adds a per-label score table with a combinational read port.
module goodness_label_select #(
    parameter int NUM_LABELS = 10,
    parameter int NUM_LAYERS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int SKIP_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          label_req,
    output logic [$clog2(NUM_LABELS)-1:0] label_idx,
    input  logic                          good_valid,
    input  logic [DATA_WIDTH-1:0]         good_in,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_LABELS)-1:0] pred_label,
    output logic [ACC_WIDTH-1:0]          best_score,
    output logic                          proto_err
`ifdef GLS_SCORE_TABLE_EN
    ,
    input  logic [$clog2(NUM_LABELS)-1:0] score_raddr,
    output logic [ACC_WIDTH-1:0]          score_rdata
`endif
);

    localparam int IDX_W = $clog2(NUM_LABELS);
    localparam int CNT_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_LABEL = IDX_W'(NUM_LABELS - 1);
    localparam logic [CNT_W-1:0] LAST_LAYER = CNT_W'(NUM_LAYERS - 1);
    localparam logic signed [ACC_WIDTH-1:0] MOST_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (ACC_WIDTH < DATA_WIDTH + $clog2(NUM_LAYERS)) begin : g_acc_width_check
        $error("ACC_WIDTH cannot hold NUM_LAYERS summed goodness values");
    end
    if (NUM_LABELS < 2) begin : g_labels_check
        $error("NUM_LABELS must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                        state_q;
    logic                          label_req_q;
    logic [IDX_W-1:0]              label_idx_q;
    logic [CNT_W-1:0]              layer_cnt_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   best_q;
    logic [IDX_W-1:0]              pred_q;
    logic                          busy_q;
    logic                          done_q;
    logic [IDX_W-1:0]              pred_label_q;
    logic [ACC_WIDTH-1:0]          best_score_q;
    logic                          proto_err_q;

    logic signed [ACC_WIDTH-1:0]   good_ext;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [ACC_WIDTH-1:0]   best_d;
    logic [IDX_W-1:0]              pred_d;
    logic                          new_best;
    logic                          last_beat;

    // Strict greater-than means a tie never displaces the earlier (lower) label.
    always_comb begin
        good_ext  = ACC_WIDTH'($signed(good_in));
        acc_d     = acc_q + good_ext;
        if ((SKIP_FIRST != 0) && (layer_cnt_q == '0)) begin
            acc_d = acc_q;
        end
        last_beat = (layer_cnt_q == LAST_LAYER);
        new_best  = (acc_q > best_q);
        best_d    = new_best ? acc_q : best_q;
        pred_d    = new_best ? label_idx_q : pred_q;
    end

`ifdef GLS_SCORE_TABLE_EN
    logic [ACC_WIDTH-1:0] score_tbl_q [NUM_LABELS];

    always_comb begin
        score_rdata = '0;
        if (score_raddr <= LAST_LABEL) begin
            score_rdata = score_tbl_q[score_raddr];
        end
    end
`endif

    // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            label_req_q  <= 1'b0;
            label_idx_q  <= '0;
            layer_cnt_q  <= '0;
            acc_q        <= '0;
            best_q       <= '0;
            pred_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pred_label_q <= '0;
            best_score_q <= '0;
            proto_err_q  <= 1'b0;
`ifdef GLS_SCORE_TABLE_EN
            // NOTE: the table is small and must read as zero after reset, so it is a reset register file, not a RAM.
            for (int i = 0; i < NUM_LABELS; i++) begin
                score_tbl_q[i] <= '0;
            end
`endif
        end else begin
            label_req_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        label_idx_q <= '0;
                        layer_cnt_q <= '0;
                        acc_q       <= '0;
                        best_q      <= MOST_NEG;
                        pred_q      <= '0;
                        proto_err_q <= 1'b0;
                        busy_q      <= 1'b1;
                        label_req_q <= 1'b1;
                        state_q     <= S_RUN;
`ifdef GLS_SCORE_TABLE_EN
                        for (int i = 0; i < NUM_LABELS; i++) begin
                            score_tbl_q[i] <= '0;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (good_valid) begin
                        acc_q       <= acc_d;
                        layer_cnt_q <= layer_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    best_q <= best_d;
                    pred_q <= pred_d;
`ifdef GLS_SCORE_TABLE_EN
                    score_tbl_q[label_idx_q] <= acc_q;
`endif
                    if (label_idx_q == LAST_LABEL) begin
                        pred_label_q <= pred_d;
                        best_score_q <= best_d;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        label_idx_q <= label_idx_q + IDX_W'(1);
                        acc_q       <= '0;
                        layer_cnt_q <= '0;
                        label_req_q <= 1'b1;
                        state_q     <= S_RUN;
                    end
                    if (good_valid) begin
                        proto_err_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (good_valid) begin
                        proto_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign label_req  = label_req_q;
    assign label_idx  = label_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pred_label = pred_label_q;
    assign best_score = best_score_q;
    assign proto_err  = proto_err_q;

endmodule
